uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the next generation of the fixed 8-bit one-bit-per-clock transmitter. Adds a built-in baud divider, configurable data width, per-frame parity mode (none/even/odd), 1 or 2 stop bits, and a valid/ready input handshake that supports back-to-back frames with zero idle gap. Sits between a byte source (FIFO or register interface) and the TX pad.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_frame.sv | 125 ++++++++++++
 tb/tb_uart_tx_frame.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/stop encodings and transmitter state type.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Mode 11 is deliberately treated like no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter 0..CLKS_PER_BIT-1 with synchronous clear; bit_end flags the last
// cycle of each bit period. No handshake, free-running while clr is low.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, 1/2 stops; line
// low the cycle after accept. tx_ready only in idle or on the final stop cycle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  output logic                 serial_out,
  output logic                 send_done,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           mode_q, mode_d;
  logic                 stop2_q, stop2_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 serial_q, serial_d;

  logic bit_end;
  logic last_stop;
  logic accept;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  // stop_cnt_q counts stops already sent; the final one is reached when it equals stop2_q.
  assign last_stop  = (state_q == ST_STOP) && (stop_cnt_q == stop2_q) && bit_end;
  assign tx_ready   = (state_q == ST_IDLE) || last_stop;
  assign accept     = tx_valid && tx_ready;
  assign send_done  = last_stop;
  assign busy       = (state_q != ST_IDLE);
  assign serial_out = serial_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    if (accept) begin
      state_d    = ST_START;
      data_d     = tx_data;
      mode_d     = parity_mode;
      stop2_d    = stop_bits;
      idx_d      = '0;
      stop_cnt_d = 1'b0;
    end else if (bit_end) begin
      case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
        ST_DATA: begin
          if (idx_q == IDX_LAST) begin
            state_d    = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop_cnt_q == stop2_q) state_d = ST_IDLE;
          else                       stop_cnt_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Line value is precomputed from the next state so serial_out comes straight from a flop.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = data_d[idx_d];
      ST_PARITY: serial_d = (mode_d == PAR_ODD) ? ~^data_d : ^data_d;
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      mode_q     <= PAR_NONE;
      stop2_q    <= STOP_ONE;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      serial_q   <= serial_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames against a per-cycle line model.
module tb_uart_tx_frame;

  localparam int DB  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic          tx_ready;
  logic [DB-1:0] tx_data;
  logic [1:0]    parity_mode;
  logic          stop_bits;
  logic          serial_out;
  logic          send_done;
  logic          busy;

  uart_tx_frame #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .serial_out (serial_out),
    .send_done  (send_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  bit chk_en   = 1'b0;
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line, one entry per clock cycle, for a whole frame.
  task automatic push_frame(input logic [DB-1:0] d, input logic [1:0] m, input logic s);
    bit bits[$];
    int ones;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (m == 2'b01) bits.push_back((ones % 2) == 1);
    if (m == 2'b10) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    if (s) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endtask

  always @(negedge clk) begin
    int  sz;
    bit  e_ser;
    sz    = exp_q.size();
    e_ser = 1'b1;
    if (sz != 0) e_ser = exp_q[0];
    if (chk_en) begin
      check("serial_out", 32'(serial_out), 32'(e_ser));
      check("tx_ready",   32'(tx_ready),   32'(sz <= 1));
      check("send_done",  32'(send_done),  32'(sz == 1));
      check("busy",       32'(busy),       32'(sz != 0));
    end
    if (reset) begin
      exp_q.delete();
    end else begin
      if (sz != 0) void'(exp_q.pop_front());
      if (tx_valid && sz <= 1) begin
        push_frame(tx_data, parity_mode, stop_bits);
        acc_cnt++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a frame and hold tx_valid until the model says it was taken.
  task automatic send(input logic [DB-1:0] d, input logic [1:0] m, input logic s);
    int start;
    int n;
    start       = acc_cnt;
    n           = 0;
    tx_data     = d;
    parity_mode = m;
    stop_bits   = s;
    tx_valid    = 1'b1;
    while (acc_cnt == start && n < 200) begin
      cycles(1);
      n++;
    end
    if (acc_cnt == start) check("accept_timeout", 32'(n), 32'd0);
    tx_valid    = 1'b0;
    tx_data     = DB'($urandom);
    parity_mode = 2'($urandom);
    stop_bits   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    if (exp_q.size() != 0) check("idle_timeout", 32'(n), 32'd0);
  endtask

  // Short tx_valid pulse well inside a frame; it must be ignored.
  task automatic pulse_mid();
    cycles(3);
    tx_data  = DB'($urandom);
    tx_valid = 1'b1;
    cycles(2);
    tx_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    cycles(2);
    chk_en = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(2);

    send(8'h55, 2'b00, 1'b0);
    wait_idle();
    cycles(2);
    send(8'h03, 2'b01, 1'b0);
    wait_idle();
    send(8'h03, 2'b10, 1'b0);
    wait_idle();
    cycles(1);
    send(8'hA5, 2'b00, 1'b1);
    wait_idle();
    cycles(3);

    send(8'h12, 2'b00, 1'b0);
    send(8'h34, 2'b00, 1'b0);
    pulse_mid();
    wait_idle();
    cycles(2);

    send(8'hC3, 2'b11, 1'b0);
    pulse_mid();
    wait_idle();

    // Reset during data bit 3: frame dropped, next frame clean.
    send(8'hF0, 2'b01, 1'b1);
    cycles(4 + 3 * CPB);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(3);

    // Reset wins over a simultaneous accept.
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    cycles(1);
    reset    = 1'b0;
    tx_valid = 1'b0;
    cycles(2);
    send(8'h5A, 2'b10, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      send(DB'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (gap == 1) pulse_mid();
      if (gap >= 2) begin
        wait_idle();
        cycles(gap - 2);
      end
    end
    wait_idle();
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
